// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with a single outstanding line fill.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req_valid, req_addr fetch lookup; req_addr[1:0] ignored
//   rsp_valid, rsp_inst same-cycle hit response
//   miss_stall          fetch must hold its PC (miss in progress)
//   flush               invalidate every line
//   mem_req_*           line-fill request (line-aligned address)
//   mem_rsp_*           fill data, one-cycle pulse, word 0 in bits [31:0]
module icache #(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [31:0]          req_addr,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_inst,
  output logic                 miss_stall,
  input  logic                 flush,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [31:0]          mem_req_addr,
  input  logic                 mem_rsp_valid,
  input  logic [LINE_BITS-1:0] mem_rsp_data
);

  localparam int unsigned OffW  = $clog2(LINE_BITS / 8);
  localparam int unsigned IdxW  = $clog2(NUM_LINES);
  localparam int unsigned TagW  = 32 - OffW - IdxW;
  localparam int unsigned Words = LINE_BITS / 32;
  localparam int unsigned WselW = OffW - 2;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StFill} state_e;

  state_e                 state_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic [TagW-1:0]        tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0]   data_q [NUM_LINES];
  logic [31:0]            miss_addr_q;
  logic [LINE_BITS-1:0]   fill_data_q;
  // A flush seen while a fill is in flight: the fill still lands but stays invalid.
  logic                   flush_pend_q;

  logic [IdxW-1:0]        req_idx, fill_idx;
  logic [TagW-1:0]        req_tag, fill_tag;
  logic [WselW-1:0]       req_word;
  logic [LINE_BITS-1:0]   req_line;
  logic                   hit;

  assign req_idx  = req_addr[OffW +: IdxW];
  assign req_tag  = req_addr[31 -: TagW];
  assign req_word = req_addr[2 +: WselW];
  assign fill_idx = miss_addr_q[OffW +: IdxW];
  assign fill_tag = miss_addr_q[31 -: TagW];
  assign req_line = data_q[req_idx];

  // A same-cycle flush forces the lookup to miss.
  assign hit = (state_q == StIdle) && req_valid && !flush && valid_q[req_idx] &&
               (tag_q[req_idx] == req_tag);

  always_comb begin
    rsp_valid  = 1'b0;
    miss_stall = 1'b0;
    rsp_inst   = '0;
    for (int unsigned w = 0; w < Words; w++) begin
      if (req_word == WselW'(w)) rsp_inst = req_line[w*32 +: 32];
    end
    if (state_q != StIdle) begin
      miss_stall = 1'b1;
    end else if (req_valid) begin
      rsp_valid  = hit;
      miss_stall = !hit;
    end
  end

  assign mem_req_valid = (state_q == StReq);
  assign mem_req_addr  = miss_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      miss_addr_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid && !hit) begin
            miss_addr_q  <= {req_addr[31:OffW], {OffW{1'b0}}};
            flush_pend_q <= 1'b0;
            state_q      <= StReq;
          end
        end
        StReq: begin
          if (mem_req_ready) state_q <= StWait;
        end
        StWait: begin
          if (mem_rsp_valid) begin
            fill_data_q <= mem_rsp_data;
            state_q     <= StFill;
          end
        end
        StFill: begin
          data_q[fill_idx] <= fill_data_q;
          tag_q[fill_idx]  <= fill_tag;
          if (!flush_pend_q) valid_q[fill_idx] <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      // Placed last so a flush overrides any valid bit set above.
      if (flush) begin
        valid_q <= '0;
        if (state_q != StIdle) flush_pend_q <= 1'b1;
      end
    end
  end

endmodule
